// File: rtl/soft_adder_pipe_if.sv
// Operation/result bundle for soft_adder_pipe.
// The master side issues operations; the slave side (the adder) returns results.
interface soft_adder_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, op, a, b, cin,
    input  out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, op, a, b, cin,
    output out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/soft_adder_pipe.sv
// Carry-pipelined soft adder/accumulator.
// WIDTH is cut into NSEG segments of SEG bits. Segment k sees item i in cycle
// i+k, together with the carry segment k-1 registered for that item one cycle
// earlier. Operands are skewed on the way in and results deskewed on the way
// out, so a whole result leaves the output register NSEG cycles after issue.

// One SEG-bit slice: operand skew, slice add, carry register, accumulator
// slice and result deskew.
module soft_adder_seg #(
  parameter int SEG  = 4,
  parameter int K    = 0,   // segment index = input skew depth
  parameter int NSEG = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           vld,       // already delayed by K
  input  logic [1:0]     op,        // already delayed by K
  input  logic [SEG-1:0] a_in,      // undelayed operand slices
  input  logic [SEG-1:0] b_in,
  input  logic           carry_in,  // resolved carry for this slot
  output logic           carry_q,
  output logic [SEG-1:0] res_al,    // slice result, aligned to stage NSEG-1
  output logic           cout,      // raw carry out of this slice
  output logic           msb_cin    // carry into the slice MSB
);
  localparam int DSK = NSEG - 1 - K;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic [SEG-1:0] a_k, b_k;

  if (K > 0) begin : g_skew
    logic [K-1:0][SEG-1:0] a_skew_q, a_skew_d, b_skew_q, b_skew_d;

    // shift operand slices K cycles so they meet this segment's carry
    always_comb begin
      a_skew_d[0] = a_in;
      b_skew_d[0] = b_in;
      for (int j = 1; j < K; j++) begin
        a_skew_d[j] = a_skew_q[j-1];
        b_skew_d[j] = b_skew_q[j-1];
      end
    end

    // skew registers
    always_ff @(posedge clk) begin
      if (reset) begin
        a_skew_q <= '0;
        b_skew_q <= '0;
      end else begin
        a_skew_q <= a_skew_d;
        b_skew_q <= b_skew_d;
      end
    end

    assign a_k = a_skew_q[K-1];
    assign b_k = b_skew_q[K-1];
  end else begin : g_noskew
    assign a_k = a_in;
    assign b_k = b_in;
  end

  logic [SEG-1:0] acc_q, acc_d;
  logic [SEG-1:0] x, y, res;
  logic [SEG:0]   tot;
  logic           carry_d;

  // slice add; acc reads the old accumulator slice, load passes a through
  always_comb begin
    x = a_k;
    y = b_k;
    case (op)
      OP_SUB:  y = ~b_k;
      OP_ACC:  begin x = acc_q; y = a_k; end
      OP_LOAD: y = '0;
      default: ;
    endcase
    tot     = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, carry_in};
    res     = (op == OP_LOAD) ? a_k : tot[SEG-1:0];
    cout    = tot[SEG];
    msb_cin = tot[SEG-1] ^ x[SEG-1] ^ y[SEG-1];
    // bubbles and loads must not leak a carry into the next slot
    carry_d = vld && (op != OP_LOAD) && tot[SEG];
    acc_d   = acc_q;
    if (vld && (op == OP_ACC || op == OP_LOAD)) acc_d = res;
  end

  // carry and accumulator slice registers
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      carry_q <= carry_d;
      acc_q   <= acc_d;
    end
  end

  if (DSK > 0) begin : g_dskw
    logic [DSK-1:0][SEG-1:0] dsk_q, dsk_d;

    // hold the slice result until the upper segments have caught up
    always_comb begin
      dsk_d[0] = res;
      for (int j = 1; j < DSK; j++) dsk_d[j] = dsk_q[j-1];
    end

    // deskew registers
    always_ff @(posedge clk) begin
      if (reset) dsk_q <= '0;
      else       dsk_q <= dsk_d;
    end

    assign res_al = dsk_q[DSK-1];
  end else begin : g_nodskw
    assign res_al = res;
  end
endmodule

module soft_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic              clk,
  input  logic              reset,
  soft_adder_pipe_if.slave  bus
);
  localparam int NSEG = WIDTH / SEG;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b11;

  if (WIDTH < 1 || SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_cfg
    $error("soft_adder_pipe: WIDTH must be a positive multiple of SEG");
  end

  // control as seen by each segment: index k = delayed k cycles
  logic [NSEG-1:0]      vld_s;
  logic [NSEG-1:0][1:0] op_s;

  assign vld_s[0] = bus.in_valid;
  assign op_s[0]  = bus.op;

  if (NSEG > 1) begin : g_ctl_skew
    logic [NSEG-2:0]      vld_pipe_q, vld_pipe_d;
    logic [NSEG-2:0][1:0] op_pipe_q, op_pipe_d;

    // valid/op shift register shared by all segments
    always_comb begin
      vld_pipe_d[0] = bus.in_valid;
      op_pipe_d[0]  = bus.op;
      for (int j = 1; j < NSEG - 1; j++) begin
        vld_pipe_d[j] = vld_pipe_q[j-1];
        op_pipe_d[j]  = op_pipe_q[j-1];
      end
    end

    // control pipeline registers
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_pipe_q <= '0;
        op_pipe_q  <= '0;
      end else begin
        vld_pipe_q <= vld_pipe_d;
        op_pipe_q  <= op_pipe_d;
      end
    end

    for (genvar k = 1; k < NSEG; k++) begin : g_tap
      assign vld_s[k] = vld_pipe_q[k-1];
      assign op_s[k]  = op_pipe_q[k-1];
    end
  end

  // carry into segment 0: forced for sub/load, cin otherwise
  logic cin0;
  always_comb begin
    case (bus.op)
      OP_SUB:  cin0 = 1'b1;
      OP_LOAD: cin0 = 1'b0;
      default: cin0 = bus.cin;
    endcase
  end

  logic [NSEG-1:0]          seg_carry_q;
  logic [NSEG-1:0]          seg_cout;
  logic [NSEG-1:0]          seg_msb;
  logic [NSEG-1:0][SEG-1:0] seg_res;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic cin_k;
    if (k == 0) begin : g_c0
      assign cin_k = cin0;
    end else begin : g_cn
      assign cin_k = seg_carry_q[k-1];
    end

    soft_adder_seg #(.SEG(SEG), .K(k), .NSEG(NSEG)) u_seg (
      .clk      (clk),
      .reset    (reset),
      .vld      (vld_s[k]),
      .op       (op_s[k]),
      .a_in     (bus.a[k*SEG +: SEG]),
      .b_in     (bus.b[k*SEG +: SEG]),
      .carry_in (cin_k),
      .carry_q  (seg_carry_q[k]),
      .res_al   (seg_res[k]),
      .cout     (seg_cout[k]),
      .msb_cin  (seg_msb[k])
    );
  end

  // only the top segment's flags reach the output and nothing consumes its
  // carry register; sink the rest here
  logic unused_seg_bits;
  assign unused_seg_bits = ^{seg_carry_q, seg_cout, seg_msb};

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] res_cat;

  assign res_cat = seg_res;

  // assemble the aligned slices; flags hold while no result is present
  always_comb begin
    out_valid_d = vld_s[NSEG-1];
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (vld_s[NSEG-1]) begin
      sum_d = res_cat;
      if (op_s[NSEG-1] == OP_LOAD) begin
        cout_d = 1'b0;
        ovf_d  = 1'b0;
      end else begin
        cout_d = seg_cout[NSEG-1];
        ovf_d  = seg_cout[NSEG-1] ^ seg_msb[NSEG-1];
      end
    end
  end

  // output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_soft_adder_pipe.sv
// Bench for soft_adder_pipe: a 16/4 instance (latency 4) and an 8/8
// single-segment instance (latency 1), both checked every cycle against an
// arithmetic model that schedules expected results by output cycle.
module tb_soft_adder_pipe;
  localparam int MAXC = 2048;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, LD = 2'b11;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  soft_adder_pipe_if #(.WIDTH(16)) if16();
  soft_adder_pipe_if #(.WIDTH(8))  if8();

  soft_adder_pipe #(.WIDTH(16), .SEG(4)) dut16 (.clk(clk), .reset(reset), .bus(if16));
  soft_adder_pipe #(.WIDTH(8),  .SEG(8)) dut8  (.clk(clk), .reset(reset), .bus(if8));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // expected outputs indexed by the cycle in which they must be visible
  logic        e16_v [MAXC];
  logic [15:0] e16_s [MAXC];
  logic        e16_c [MAXC];
  logic        e16_o [MAXC];
  logic        e8_v  [MAXC];
  logic [7:0]  e8_s  [MAXC];
  logic        e8_c  [MAXC];
  logic        e8_o  [MAXC];
  logic [31:0] acc16 = '0;
  logic [31:0] acc8  = '0;

  // whole-word arithmetic reference for a w-bit adder/accumulator
  function automatic res_t model(input int w, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, inout logic [31:0] acc);
    logic [32:0] mask, x, y, c, full;
    res_t r;
    mask = (33'd1 << w) - 33'd1;
    r = '0;
    if (op == LD) begin
      acc   = a & mask[31:0];
      r.sum = acc;
      return r;
    end
    x = {1'b0, a} & mask;
    y = {1'b0, b} & mask;
    c = {32'd0, cin};
    if (op == SUB) begin y = ~{1'b0, b} & mask; c = 33'd1; end
    if (op == ACC) begin x = {1'b0, acc} & mask; y = {1'b0, a} & mask; end
    full  = x + y + c;
    r.sum = full[31:0] & mask[31:0];
    r.cout = full[w];
    r.ovf  = (x[w-1] == y[w-1]) && (r.sum[w-1] != x[w-1]);
    if (op == ACC) acc = r.sum;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic drv16(input logic v, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, output res_t r);
    if16.in_valid = v; if16.op = op; if16.a = a; if16.b = b; if16.cin = cin;
    r = '0;
    if (v && !reset) begin
      r = model(16, op, {16'd0, a}, {16'd0, b}, cin, acc16);
      if (cyc + 4 < MAXC) begin
        e16_v[cyc+4] = 1'b1; e16_s[cyc+4] = r.sum[15:0];
        e16_c[cyc+4] = r.cout; e16_o[cyc+4] = r.ovf;
      end
    end
  endtask

  task automatic drv8(input logic v, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic cin, output res_t r);
    if8.in_valid = v; if8.op = op; if8.a = a; if8.b = b; if8.cin = cin;
    r = '0;
    if (v && !reset) begin
      r = model(8, op, {24'd0, a}, {24'd0, b}, cin, acc8);
      if (cyc + 1 < MAXC) begin
        e8_v[cyc+1] = 1'b1; e8_s[cyc+1] = r.sum[7:0];
        e8_c[cyc+1] = r.cout; e8_o[cyc+1] = r.ovf;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // raise reset for the current cycle: everything in flight is dropped
  task automatic rst_begin();
    reset = 1'b1;
    acc16 = '0;
    acc8  = '0;
    for (int j = 1; j <= 4; j++) if (cyc + j < MAXC) e16_v[cyc+j] = 1'b0;
    if (cyc + 1 < MAXC) e8_v[cyc+1] = 1'b0;
  endtask

  // per-cycle comparison of both DUTs against the schedule
  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      check("out_valid16", if16.out_valid, e16_v[cyc]);
      if (e16_v[cyc]) begin
        check("sum16", if16.sum, e16_s[cyc]);
        check("cout16", if16.cout, e16_c[cyc]);
        check("ovf16", if16.ovf, e16_o[cyc]);
      end
      check("out_valid8", if8.out_valid, e8_v[cyc]);
      if (e8_v[cyc]) begin
        check("sum8", if8.sum, e8_s[cyc]);
        check("cout8", if8.cout, e8_c[cyc]);
        check("ovf8", if8.ovf, e8_o[cyc]);
      end
    end
  end

  initial begin
    res_t r, r8;
    for (int j = 0; j < MAXC; j++) begin
      e16_v[j] = 1'b0; e16_s[j] = '0; e16_c[j] = 1'b0; e16_o[j] = 1'b0;
      e8_v[j]  = 1'b0; e8_s[j]  = '0; e8_c[j]  = 1'b0; e8_o[j]  = 1'b0;
    end
    drv16(1'b0, ADD, 16'h0, 16'h0, 1'b0, r);
    drv8(1'b0, ADD, 8'h0, 8'h0, 1'b0, r8);

    // reset state
    step();
    chk_en = 1'b1;
    check("rst_sum16", if16.sum, 32'h0);
    check("rst_cout16", if16.cout, 32'h0);
    check("rst_ovf16", if16.ovf, 32'h0);
    check("rst_sum8", if8.sum, 32'h0);
    step();
    reset = 1'b0;

    // carry ripples through every segment; single-segment signed overflow
    drv16(1'b1, ADD, 16'hFFFF, 16'h0001, 1'b0, r);
    check("pin_ripple_sum", r.sum, 32'h0000);
    check("pin_ripple_cout", r.cout, 32'h1);
    check("pin_ripple_ovf", r.ovf, 32'h0);
    drv8(1'b1, ADD, 8'h7F, 8'h01, 1'b0, r8);
    check("pin_seg1_sum", r8.sum, 32'h80);
    check("pin_seg1_cout", r8.cout, 32'h0);
    check("pin_seg1_ovf", r8.ovf, 32'h1);
    step();
    drv8(1'b0, ADD, 8'h0, 8'h0, 1'b0, r8);

    // signed subtract overflow, then a plain borrow
    drv16(1'b1, SUB, 16'h8000, 16'h0001, 1'b0, r);
    check("pin_subovf_sum", r.sum, 32'h7FFF);
    check("pin_subovf_cout", r.cout, 32'h1);
    check("pin_subovf_ovf", r.ovf, 32'h1);
    step();
    drv16(1'b1, SUB, 16'h0000, 16'h0001, 1'b0, r);
    check("pin_borrow_sum", r.sum, 32'hFFFF);
    check("pin_borrow_cout", r.cout, 32'h0);
    check("pin_borrow_ovf", r.ovf, 32'h0);
    step();

    // back-to-back accumulate
    drv16(1'b1, LD, 16'h0010, 16'h0, 1'b0, r);  check("pin_b2b0", r.sum, 32'h0010); step();
    drv16(1'b1, ACC, 16'h00F0, 16'h0, 1'b0, r); check("pin_b2b1", r.sum, 32'h0100); step();
    drv16(1'b1, ACC, 16'hFF00, 16'h0, 1'b0, r); check("pin_b2b2", r.sum, 32'h0000);
    check("pin_b2b2_cout", r.cout, 32'h1); step();
    drv16(1'b1, ACC, 16'h0001, 16'h0, 1'b0, r); check("pin_b2b3", r.sum, 32'h0001); step();

    // bubbles interleaved; the add leaves the accumulator alone
    drv16(1'b1, LD, 16'h0003, 16'h0, 1'b0, r);     check("pin_bub0", r.sum, 32'h0003); step();
    drv16(1'b0, ADD, 16'h0, 16'h0, 1'b0, r);       step();
    drv16(1'b1, ADD, 16'h1111, 16'h2222, 1'b0, r); check("pin_bub1", r.sum, 32'h3333); step();
    drv16(1'b0, ADD, 16'h0, 16'h0, 1'b0, r);       step();
    drv16(1'b1, ACC, 16'h0004, 16'h0, 1'b0, r);    check("pin_bub2", r.sum, 32'h0007); step();

    // reset with three accumulates in flight, input during reset ignored
    drv16(1'b1, ACC, 16'h0001, 16'h0, 1'b0, r); step();
    drv16(1'b1, ACC, 16'h0002, 16'h0, 1'b0, r); step();
    drv16(1'b1, ACC, 16'h0003, 16'h0, 1'b0, r); step();
    rst_begin();
    drv16(1'b1, ACC, 16'h0009, 16'h0, 1'b1, r);
    step();
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin drv16(1'b0, ADD, 16'h0, 16'h0, 1'b0, r); step(); end
    drv16(1'b1, ACC, 16'h0005, 16'h0, 1'b0, r); check("pin_post_rst", r.sum, 32'h0005); step();
    drv16(1'b0, ADD, 16'h0, 16'h0, 1'b0, r);
    for (int j = 0; j < 5; j++) step();

    // random mix with occasional resets
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(0, 99) == 0) rst_begin();
      drv16(($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)), 16'($urandom),
            16'($urandom), 1'($urandom), r);
      drv8(($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)), 8'($urandom),
           8'($urandom), 1'($urandom), r8);
      step();
      reset = 1'b0;
    end
    drv16(1'b0, ADD, 16'h0, 16'h0, 1'b0, r);
    drv8(1'b0, ADD, 8'h0, 8'h0, 1'b0, r8);
    for (int j = 0; j < 6; j++) step();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
